// File: rtl/reg_alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// reg_alu_seq_pkg
// Shared definitions for the reg_alu instruction sequencer: instruction field
// positions, opcode values, FSM state encoding, the decoded control bundle
// and the immediate-extension helper.
// -----------------------------------------------------------------------------
package reg_alu_seq_pkg;

    localparam int INSTR_W = 16;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 3;
    localparam int ALUOP_W = 2;
    localparam int IMM_W   = 10;
    localparam int OPC_W   = 3;

    // Instruction field positions (LSB of each field)
    localparam int OPC_LSB    = 13;  // [15:13] opcode
    localparam int LDI_WA_LSB = 10;  // [12:10] LDI write address
    localparam int IMM_LSB    = 0;   // [9:0]   LDI immediate
    localparam int ALU_OP_LSB = 11;  // [12:11] ALU operation
    localparam int ALU_WA_LSB = 8;   // [10:8]  ALU write address
    localparam int ALU_RA_LSB = 5;   // [7:5]   ALU read address A
    localparam int ALU_RB_LSB = 2;   // [4:2]   ALU read address B
    localparam int RD_RA_LSB  = 10;  // [12:10] RD read address A
    localparam int RD_RB_LSB  = 7;   // [9:7]   RD read address B

    // Opcodes; 100/101/110 are undefined
    localparam logic [OPC_W-1:0] OP_NOP  = 3'b000;
    localparam logic [OPC_W-1:0] OP_LDI  = 3'b001;
    localparam logic [OPC_W-1:0] OP_ALU  = 3'b010;
    localparam logic [OPC_W-1:0] OP_RD   = 3'b011;
    localparam logic [OPC_W-1:0] OP_HALT = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        CFLAG = 2'd2,
        HALT  = 2'd3
    } state_e;

    // Decoded controls. Each upd_* flag says whether the instruction defines
    // that field; fields it does not define keep their previous value.
    typedef struct packed {
        logic               wr;
        logic               upd_sel;
        logic               sel;
        logic               upd_op;
        logic [ALUOP_W-1:0] op;
        logic               upd_wa;
        logic [ADDR_W-1:0]  wa;
        logic               upd_ra;
        logic [ADDR_W-1:0]  ra;
        logic               upd_rb;
        logic [ADDR_W-1:0]  rb;
        logic               upd_imm;
        logic [IMM_W-1:0]   imm;
        logic               is_alu;
        logic               is_halt;
    } ctrl_t;

    function automatic logic [DATA_W-1:0] extend_imm(input logic [IMM_W-1:0] imm,
                                                     input logic             sext);
        extend_imm = {{(DATA_W-IMM_W){sext & imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/reg_alu_seq_dec.sv
// -----------------------------------------------------------------------------
// reg_alu_seq_dec
// Purely combinational instruction decoder.
//   i_instr   : 16-bit instruction word
//   o_ctrl    : decoded control bundle (field values plus update flags)
//   o_illegal : opcode is undefined; bundle is all-zero (behaves as NOP)
// -----------------------------------------------------------------------------
module reg_alu_seq_dec
    import reg_alu_seq_pkg::*;
(
    input  logic [INSTR_W-1:0] i_instr,
    output ctrl_t              o_ctrl,
    output logic               o_illegal
);

    logic [OPC_W-1:0] w_opc;
    assign w_opc = i_instr[OPC_LSB +: OPC_W];

    // NOTE: every output of a combinational block gets a default before the
    // case statement, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        o_ctrl    = '0;
        o_illegal = 1'b0;
        case (w_opc)
            OP_NOP: begin
            end
            OP_LDI: begin
                o_ctrl.wr      = 1'b1;
                o_ctrl.upd_sel = 1'b1;
                o_ctrl.sel     = 1'b0;
                o_ctrl.upd_wa  = 1'b1;
                o_ctrl.wa      = i_instr[LDI_WA_LSB +: ADDR_W];
                o_ctrl.upd_imm = 1'b1;
                o_ctrl.imm     = i_instr[IMM_LSB +: IMM_W];
            end
            OP_ALU: begin
                o_ctrl.wr      = 1'b1;
                o_ctrl.upd_sel = 1'b1;
                o_ctrl.sel     = 1'b1;
                o_ctrl.upd_op  = 1'b1;
                o_ctrl.op      = i_instr[ALU_OP_LSB +: ALUOP_W];
                o_ctrl.upd_wa  = 1'b1;
                o_ctrl.wa      = i_instr[ALU_WA_LSB +: ADDR_W];
                o_ctrl.upd_ra  = 1'b1;
                o_ctrl.ra      = i_instr[ALU_RA_LSB +: ADDR_W];
                o_ctrl.upd_rb  = 1'b1;
                o_ctrl.rb      = i_instr[ALU_RB_LSB +: ADDR_W];
                o_ctrl.is_alu  = 1'b1;
            end
            OP_RD: begin
                o_ctrl.upd_ra  = 1'b1;
                o_ctrl.ra      = i_instr[RD_RA_LSB +: ADDR_W];
                o_ctrl.upd_rb  = 1'b1;
                o_ctrl.rb      = i_instr[RD_RB_LSB +: ADDR_W];
            end
            OP_HALT: begin
                o_ctrl.is_halt = 1'b1;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/reg_alu_seq.sv
// -----------------------------------------------------------------------------
// reg_alu_seq
// Instruction sequencer driving the control inputs of reg_alu.
//   clk, reset          : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   : instruction handshake; instr must be held until taken
//   instr               : 16-bit instruction word
//   sel, wr, op         : reg_alu source select, write enable, ALU operation
//   rd_addr_a/b, wr_addr: register-file addresses
//   d_in                : extended immediate
//   cout                : registered carry returned by reg_alu
//   carry, carry_vld    : captured carry and its one-cycle update pulse
//   halted, illegal     : HALT executed; sticky undefined-opcode flag
//   retired             : wrapping count of retired legal instructions
// -----------------------------------------------------------------------------
module reg_alu_seq
    import reg_alu_seq_pkg::*;
#(
    parameter bit SEXT_IMM = 1'b0,
    parameter int RET_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic               sel,
    output logic               wr,
    output logic [ALUOP_W-1:0] op,
    output logic [ADDR_W-1:0]  rd_addr_a,
    output logic [ADDR_W-1:0]  rd_addr_b,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [DATA_W-1:0]  d_in,
    input  logic               cout,
    output logic               carry,
    output logic               carry_vld,
    output logic               halted,
    output logic               illegal,
    output logic [RET_W-1:0]   retired
);

    state_e             r_state;
    state_e             w_state_nxt;
    ctrl_t              w_ctrl;
    logic               w_illegal;
    logic               w_accept;
    logic               w_in_ready;

    logic               r_sel;
    logic               r_wr;
    logic [ALUOP_W-1:0] r_op;
    logic [ADDR_W-1:0]  r_rd_a;
    logic [ADDR_W-1:0]  r_rd_b;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [DATA_W-1:0]  r_d_in;
    logic               r_carry;
    logic               r_carry_vld;
    logic               r_illegal;
    logic [RET_W-1:0]   r_retired;
    logic               r_is_alu;
    logic               r_is_halt;
    logic               r_retire;

    reg_alu_seq_dec u_dec (
        .i_instr   (instr),
        .o_ctrl    (w_ctrl),
        .o_illegal (w_illegal)
    );

    // ---------------------------------------------------------------- FSM ---
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) w_state_nxt = EXEC;
            end
            EXEC: begin
                if (r_is_alu)       w_state_nxt = CFLAG;
                else if (r_is_halt) w_state_nxt = HALT;
                else                w_state_nxt = IDLE;
            end
            CFLAG:   w_state_nxt = IDLE;
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = IDLE;
        endcase
    end

    // in_ready is held low while reset is asserted even though the state is IDLE.
    assign w_accept = w_in_ready & in_valid;

    // ----------------------------------------------------------- datapath ---
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel       <= 1'b0;
            r_wr        <= 1'b0;
            r_op        <= '0;
            r_rd_a      <= '0;
            r_rd_b      <= '0;
            r_wr_addr   <= '0;
            r_d_in      <= '0;
            r_carry     <= 1'b0;
            r_carry_vld <= 1'b0;
            r_illegal   <= 1'b0;
            r_retired   <= '0;
            r_is_alu    <= 1'b0;
            r_is_halt   <= 1'b0;
            r_retire    <= 1'b0;
        end else begin
            // The carry reg_alu produced at the EXEC-ending edge is sampled
            // one edge later, then flagged for exactly one cycle.
            r_carry_vld <= (r_state == CFLAG);
            if (r_state == CFLAG) r_carry <= cout;

            if (w_accept) begin
                r_wr      <= w_ctrl.wr;
                r_is_alu  <= w_ctrl.is_alu;
                r_is_halt <= w_ctrl.is_halt;
                r_retire  <= ~w_illegal;
                if (w_ctrl.upd_sel) r_sel     <= w_ctrl.sel;
                if (w_ctrl.upd_op)  r_op      <= w_ctrl.op;
                if (w_ctrl.upd_wa)  r_wr_addr <= w_ctrl.wa;
                if (w_ctrl.upd_ra)  r_rd_a    <= w_ctrl.ra;
                if (w_ctrl.upd_rb)  r_rd_b    <= w_ctrl.rb;
                if (w_ctrl.upd_imm) r_d_in    <= extend_imm(w_ctrl.imm, SEXT_IMM);
                if (w_illegal)      r_illegal <= 1'b1;
            end else if (r_state == EXEC) begin
                r_wr <= 1'b0;
            end

            if (r_state == EXEC && r_retire) r_retired <= r_retired + RET_W'(1);
        end
    end

    // ------------------------------------------------------------ outputs ---
    assign in_ready  = w_in_ready & reset;
    // Gated directly so a write strobe can never outlive an asserted reset.
    assign wr        = r_wr & reset;
    assign sel       = r_sel;
    assign op        = r_op;
    assign rd_addr_a = r_rd_a;
    assign rd_addr_b = r_rd_b;
    assign wr_addr   = r_wr_addr;
    assign d_in      = r_d_in;
    assign carry     = r_carry;
    assign carry_vld = r_carry_vld;
    assign halted    = (r_state == HALT);
    assign illegal   = r_illegal;
    assign retired   = r_retired;

endmodule

// File: tb/tb_reg_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_reg_alu_seq
// Two sequencers share all inputs: u_dut0 zero-extends with a 4-bit retire
// counter (so wrap is reachable), u_dut1 sign-extends with a 16-bit counter.
// -----------------------------------------------------------------------------
module tb_reg_alu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] instr;
    logic        cout;

    logic        in_ready, sel, wr, carry, carry_vld, halted, illegal;
    logic [1:0]  op;
    logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
    logic [15:0] d_in;
    logic [3:0]  retired;

    logic        in_ready_1, sel_1, wr_1, carry_1, carry_vld_1, halted_1, illegal_1;
    logic [1:0]  op_1;
    logic [2:0]  rd_addr_a_1, rd_addr_b_1, wr_addr_1;
    logic [15:0] d_in_1;
    logic [15:0] retired_1;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_ret  = 0;

    always #5 clk = ~clk;

    reg_alu_seq #(.SEXT_IMM(1'b0), .RET_W(4)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .sel(sel), .wr(wr), .op(op), .rd_addr_a(rd_addr_a),
        .rd_addr_b(rd_addr_b), .wr_addr(wr_addr), .d_in(d_in), .cout(cout),
        .carry(carry), .carry_vld(carry_vld), .halted(halted),
        .illegal(illegal), .retired(retired)
    );

    reg_alu_seq #(.SEXT_IMM(1'b1), .RET_W(16)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_1),
        .instr(instr), .sel(sel_1), .wr(wr_1), .op(op_1), .rd_addr_a(rd_addr_a_1),
        .rd_addr_b(rd_addr_b_1), .wr_addr(wr_addr_1), .d_in(d_in_1), .cout(cout),
        .carry(carry_1), .carry_vld(carry_vld_1), .halted(halted_1),
        .illegal(illegal_1), .retired(retired_1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Waits (bounded) for in_ready, presents the word for one accept edge and
    // returns 1 ns into the EXEC cycle.
    task automatic send(input logic [15:0] w, input string name);
        int k = 0;
        while (in_ready !== 1'b1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        check({name, "_ready"}, {31'd0, in_ready}, 32'd1);
        instr    = w;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] instr;
        logic        wr;
        logic        sel;
        logic [1:0]  op;
        logic [2:0]  wa;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [15:0] d0;
        logic [15:0] d1;
        logic        ill;
        logic        ret;
    } vec_t;

    vec_t tv[13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_vld;
        logic [15:0] held_d;

        // instr wr sel op wa ra rb d_in(zext) d_in(sext) illegal retires
        tv[0]  = '{16'h2EA5, 1'b1, 1'b0, 2'd0, 3'd3, 3'd0, 3'd0, 16'h02A5, 16'hFEA5, 1'b0, 1'b1};
        tv[1]  = '{16'h27FF, 1'b1, 1'b0, 2'd0, 3'd1, 3'd0, 3'd0, 16'h03FF, 16'hFFFF, 1'b0, 1'b1};
        tv[2]  = '{16'h2801, 1'b1, 1'b0, 2'd0, 3'd2, 3'd0, 3'd0, 16'h0001, 16'h0001, 1'b0, 1'b1};
        tv[3]  = '{16'h4428, 1'b1, 1'b1, 2'd0, 3'd4, 3'd1, 3'd2, 16'h0001, 16'h0001, 1'b0, 1'b1};
        tv[4]  = '{16'h5DDC, 1'b1, 1'b1, 2'd3, 3'd5, 3'd6, 3'd7, 16'h0001, 16'h0001, 1'b0, 1'b1};
        tv[5]  = '{16'h7580, 1'b0, 1'b1, 2'd3, 3'd5, 3'd5, 3'd3, 16'h0001, 16'h0001, 1'b0, 1'b1};
        tv[6]  = '{16'h0000, 1'b0, 1'b1, 2'd3, 3'd5, 3'd5, 3'd3, 16'h0001, 16'h0001, 1'b0, 1'b1};
        tv[7]  = '{16'h1FFF, 1'b0, 1'b1, 2'd3, 3'd5, 3'd5, 3'd3, 16'h0001, 16'h0001, 1'b0, 1'b1};
        tv[8]  = '{16'hBFFF, 1'b0, 1'b1, 2'd3, 3'd5, 3'd5, 3'd3, 16'h0001, 16'h0001, 1'b1, 1'b0};
        tv[9]  = '{16'h8123, 1'b0, 1'b1, 2'd3, 3'd5, 3'd5, 3'd3, 16'h0001, 16'h0001, 1'b1, 1'b0};
        tv[10] = '{16'hC456, 1'b0, 1'b1, 2'd3, 3'd5, 3'd5, 3'd3, 16'h0001, 16'h0001, 1'b1, 1'b0};
        tv[11] = '{16'h3E00, 1'b1, 1'b0, 2'd3, 3'd7, 3'd5, 3'd3, 16'h0200, 16'hFE00, 1'b1, 1'b1};
        tv[12] = '{16'h21FF, 1'b1, 1'b0, 2'd3, 3'd0, 3'd5, 3'd3, 16'h01FF, 16'h01FF, 1'b1, 1'b1};

        // ---- reset state
        reset = 1'b0; in_valid = 1'b0; instr = 16'h0000; cout = 1'b0;
        #12;
        check("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("rst_wr", {31'd0, wr}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("idle_sel", {31'd0, sel}, 32'd0);
        check("idle_wr", {31'd0, wr}, 32'd0);
        check("idle_op", {30'd0, op}, 32'd0);
        check("idle_addrs", {23'd0, rd_addr_a, rd_addr_b, wr_addr}, 32'd0);
        check("idle_d_in", {16'd0, d_in}, 32'd0);
        check("idle_flags", {28'd0, carry, carry_vld, halted, illegal}, 32'd0);
        check("idle_retired", {28'd0, retired}, 32'd0);

        // ---- table-driven single instructions
        for (int i = 0; i < 13; i++) begin
            string nm;
            nm = $sformatf("v%0d", i);
            send(tv[i].instr, nm);
            check({nm, "_wr"}, {31'd0, wr}, {31'd0, tv[i].wr});
            check({nm, "_sel"}, {31'd0, sel}, {31'd0, tv[i].sel});
            check({nm, "_op"}, {30'd0, op}, {30'd0, tv[i].op});
            check({nm, "_wr_addr"}, {29'd0, wr_addr}, {29'd0, tv[i].wa});
            check({nm, "_rd_a"}, {29'd0, rd_addr_a}, {29'd0, tv[i].ra});
            check({nm, "_rd_b"}, {29'd0, rd_addr_b}, {29'd0, tv[i].rb});
            check({nm, "_d_in_zext"}, {16'd0, d_in}, {16'd0, tv[i].d0});
            check({nm, "_d_in_sext"}, {16'd0, d_in_1}, {16'd0, tv[i].d1});
            check({nm, "_illegal"}, {31'd0, illegal}, {31'd0, tv[i].ill});
            check({nm, "_exec_busy"}, {31'd0, in_ready}, 32'd0);
            if (tv[i].ret) exp_ret++;
            tick();
            check({nm, "_wr_after"}, {31'd0, wr}, 32'd0);
            check({nm, "_retired"}, {28'd0, retired}, exp_ret & 32'hF);
            check({nm, "_retired16"}, {16'd0, retired_1}, exp_ret & 32'hFFFF);
        end

        // ---- ALU carry capture: cout high only during CFLAG
        cout = 1'b0;
        send(16'h4428, "alu_c1");
        exp_ret++;
        tick();
        check("c1_cflag_ready", {31'd0, in_ready}, 32'd0);
        check("c1_cflag_vld", {31'd0, carry_vld}, 32'd0);
        cout = 1'b1;
        tick();
        cout = 1'b0;
        check("c1_vld", {31'd0, carry_vld}, 32'd1);
        check("c1_carry", {31'd0, carry}, 32'd1);
        tick();
        check("c1_vld_pulse", {31'd0, carry_vld}, 32'd0);
        check("c1_carry_hold", {31'd0, carry}, 32'd1);

        // cout high during EXEC only: must not be captured early
        cout = 1'b1;
        send(16'h5DDC, "alu_c2");
        exp_ret++;
        tick();
        cout = 1'b0;
        check("c2_cflag_carry_old", {31'd0, carry}, 32'd1);
        tick();
        check("c2_vld", {31'd0, carry_vld}, 32'd1);
        check("c2_carry", {31'd0, carry}, 32'd0);

        // ---- retire counter wrap on the 4-bit instance
        for (int k = 0; k < 16 && (exp_ret & 15) != 15; k++) begin
            send(16'h0000, "nop_fill");
            tick();
            exp_ret++;
        end
        check("ret_all_ones", {28'd0, retired}, 32'hF);
        send(16'h0000, "nop_wrap");
        tick();
        exp_ret++;
        check("ret_wrap", {28'd0, retired}, 32'h0);
        check("ret_wide", {16'd0, retired_1}, exp_ret & 32'hFFFF);

        // ---- HALT with a held instruction
        held_d = d_in;
        send(16'hE000, "halt");
        check("halt_exec_wr", {31'd0, wr}, 32'd0);
        exp_ret++;
        instr    = 16'h2EA5;
        in_valid = 1'b1;
        tick();
        check("halt_halted", {31'd0, halted}, 32'd1);
        check("halt_retired", {16'd0, retired_1}, exp_ret & 32'hFFFF);
        repeat (4) tick();
        check("halt_stay", {31'd0, halted}, 32'd1);
        check("halt_no_ready", {31'd0, in_ready}, 32'd0);
        check("halt_no_wr", {31'd0, wr}, 32'd0);
        check("halt_d_in_kept", {16'd0, d_in}, {16'd0, held_d});
        check("halt_no_retire", {16'd0, retired_1}, exp_ret & 32'hFFFF);
        reset = 1'b0;
        #2;
        check("halt_rst_clear", {31'd0, halted}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_halt_ready", {31'd0, in_ready}, 32'd1);
        check("post_halt_state", {31'd0, halted}, 32'd0);
        check("post_halt_illegal", {31'd0, illegal}, 32'd0);
        check("post_halt_retired", {16'd0, retired_1}, 32'd0);

        // ---- reset during ALU EXEC
        send(16'h4428, "alu_abort");
        check("abort_wr_before", {31'd0, wr}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_wr_drop", {31'd0, wr}, 32'd0);
        check("abort_ready_low", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen_vld = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (carry_vld === 1'b1) seen_vld = 1'b1;
        end
        check("abort_no_carry_vld", {31'd0, seen_vld}, 32'd0);
        check("abort_idle_ready", {31'd0, in_ready}, 32'd1);
        check("abort_retired", {28'd0, retired}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_alu_seq.md
Name: reg_alu_seq

Overview:
- Instruction sequencer that sits directly upstream of reg_alu.
- Accepts 16-bit instruction words over a valid/ready handshake, decodes them, and drives the reg_alu control inputs: sel, wr, op, read/write addresses and d_in.
- Captures the registered ALU carry returned by reg_alu, signals when that carry is valid, and keeps a retired-instruction count.

Parameters:
- SEXT_IMM, 0, 1 = sign-extend the 10-bit immediate to 16 bits; 0 = zero-extend.
- RET_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction word present.
- in_ready  out  1  sequencer can accept an instruction.
- instr  in  16  instruction word.
- sel  out  1  reg_alu data source: 0 = d_in, 1 = ALU result.
- wr  out  1  register-file write enable.
- op  out  2  ALU operation.
- rd_addr_a  out  3  read port A address.
- rd_addr_b  out  3  read port B address.
- wr_addr  out  3  write address.
- d_in  out  16  immediate data.
- cout  in  1  registered carry from reg_alu.
- carry  out  1  captured carry of the last ALU instruction.
- carry_vld  out  1  one-cycle pulse; carry has just been updated.
- halted  out  1  HALT executed.
- illegal  out  1  sticky; an undefined opcode was received.
- retired  out  RET_W  count of retired instructions.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; every output is 0 except in_ready, which is 1 once reset deasserts in IDLE. Reset asserted mid-instruction aborts it; any wr pulse already in flight is dropped combinationally.
- Opcode is instr[15:13]:
  - 000 NOP.
  - 001 LDI: wr_addr=[12:10], imm=[9:0], sel=0, wr=1.
  - 010 ALU: op=[12:11], wr_addr=[10:8], rd_addr_a=[7:5], rd_addr_b=[4:2], sel=1, wr=1.
  - 011 RD: rd_addr_a=[12:10], rd_addr_b=[9:7], wr=0.
  - 111 HALT.
  - 100/101/110: illegal.
- FSM states: IDLE, EXEC, CFLAG, HALT.
  - IDLE: in_ready=1. On in_valid, decode is registered into the output controls at the accept edge, then go to EXEC. In IDLE, wr=0 and the other controls hold their last values.
  - EXEC: exactly one cycle. Controls are stable, wr is as decoded, in_ready=0. The register file writes at the EXEC-ending edge.
    - ALU goes to CFLAG.
    - HALT goes to HALT.
    - All other opcodes go to IDLE.
  - CFLAG: one cycle. carry<=cout at the CFLAG-ending edge, carry_vld=1 during the following cycle. The next state is IDLE and in_ready=0 in CFLAG.
  - HALT: in_ready=0 and halted=1 until reset. Held instr/in_valid inputs are ignored.
- Latency: accept at edge E0, register write at E1. For ALU, carry_vld is high in the cycle after E2.
- Throughput:
  - NOP/LDI/RD: one instruction per 2 cycles.
  - ALU: one per 3 cycles.
- Illegal opcode: treated as NOP (wr=0), sets illegal (sticky until reset), and is not counted in retired.
- retired increments by 1 at the EXEC-ending edge for NOP, LDI, ALU, RD and HALT. It wraps from all-ones to 0 with no flag.
- Immediate: d_in = zero- or sign-extend of imm per SEXT_IMM. d_in holds its value for non-LDI instructions.
- in_valid with in_ready=0: no accept. The source must hold instr stable until accepted.
- A back-to-back write to a register followed by a read of it is safe because the write lands at the EXEC edge, before the next EXEC.

Decomposition:
- Shared package reg_alu_seq_pkg:
  - opcode constants: OP_NOP, OP_LDI, OP_ALU, OP_RD, OP_HALT.
  - state enum: IDLE, EXEC, CFLAG, HALT.
  - field-position constants.
- One sub-module, reg_alu_seq_dec: purely combinational instr → control bundle plus an illegal flag. The FSM, registers and counter stay in the top module.

Test Plan:
- Release reset with in_valid=0 → all outputs 0 except in_ready=1, and retired=0.
- LDI r3, 0x2A5 with SEXT_IMM=0 → in EXEC: wr=1, sel=0, wr_addr=3, d_in=0x02A5. With SEXT_IMM=1 → d_in=0xFEA5. retired=1.
- LDI r1 0x3FF (SEXT=0); LDI r2 0x001; ALU op=add, wr r4, a=r1, b=r2 → in EXEC: sel=1, wr=1, op, a=1, b=2, wr_addr=4. Two cycles later carry_vld=1 for one cycle, with carry equal to the cout presented by reg_alu.
- Opcode 101 → wr=0 and illegal=1 (stays set). retired is unchanged, and the next legal instruction is accepted normally.
- HALT then in_valid=1 held → halted=1, in_ready=0 and no further accepts. Reset pulse → back to IDLE with halted=0.
- Assert reset during ALU EXEC → wr drops to 0 immediately and carry_vld never pulses. Separately, preload retired to all-ones via instructions → the next retire wraps it to 0.
